cmp_pipe: RTL and testbench

- Parametrised, pipelined branch-condition resolution unit; successor to the single-cycle combinational branch comparator.
- Sits in the execute stage of the pipelined RV32IM core. Evaluates the six RV32 branch conditions on a WIDTH-bit operand pair, compares the result with the fetch-stage prediction, and returns the result after STAGES cycles.
- Provides valid/ready flow control, flush, illegal-funct3 detection and branch/mispredict statistics counters.

---
 rtl/cmp_pipe_if.sv | 37 +++
 rtl/cmp_pipe.sv | 154 +++++++++++++++
 tb/tb_cmp_pipe.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_pipe_if.sv
// Request/result bundle of the branch-condition resolution unit.
// master = requester/consumer side, slave = cmp_pipe itself.
interface cmp_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       cmpop;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] cmpmux;
    logic             pred_taken;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic             br_en;
    logic             mispredict;
    logic             illegal;
    logic [TAG_W-1:0] tag_out;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    // Valid/ready: a transfer happens at a clk edge where valid and ready are both 1
    // (input side additionally needs flush=0); the producer holds its payload until then.
    modport master (
        output flush, in_valid, cmpop, rs1, cmpmux, pred_taken, tag_in, out_ready,
        input  in_ready, out_valid, br_en, mispredict, illegal, tag_out,
               resolved_cnt, mispredict_cnt
    );
    modport slave (
        input  flush, in_valid, cmpop, rs1, cmpmux, pred_taken, tag_in, out_ready,
        output in_ready, out_valid, br_en, mispredict, illegal, tag_out,
               resolved_cnt, mispredict_cnt
    );
endinterface

// File: rtl/cmp_pipe.sv
// Pipelined RV32 branch-condition resolution with prediction check,
// valid/ready flow control, flush and branch/mispredict statistics.
module cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      rst,
    cmp_pipe_if.slave bus
);
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("cmp_pipe: STAGES must be 1 or 2");
    end
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("cmp_pipe: WIDTH must be in 8..64");
    end

    typedef struct packed {
        logic             br_en;
        logic             mispredict;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    function automatic res_t resolve(input logic [2:0] op, input logic eq, input logic lts,
                                     input logic ltu, input logic pred,
                                     input logic [TAG_W-1:0] tag);
        res_t r;
        r.br_en   = 1'b0;
        r.illegal = 1'b0;
        r.tag     = tag;
        case (op)
            3'b000:  r.br_en = eq;
            3'b001:  r.br_en = !eq;
            3'b100:  r.br_en = lts;
            3'b101:  r.br_en = !lts;
            3'b110:  r.br_en = ltu;
            3'b111:  r.br_en = !ltu;
            default: r.illegal = 1'b1;
        endcase
        r.mispredict = !r.illegal && (r.br_en != pred);
        return r;
    endfunction

    logic eq_c, lts_c, ltu_c;
    assign eq_c  = (bus.rs1 == bus.cmpmux);
    assign lts_c = ($signed(bus.rs1) < $signed(bus.cmpmux));
    assign ltu_c = (bus.rs1 < bus.cmpmux);

    logic [STAGES-1:0] vld_q, vld_d;
    res_t              res_q, res_d;
    logic              in_adv;
    logic              out_valid;
    logic              out_xfer;
    logic [CNT_W-1:0]  resolved_cnt_q, resolved_cnt_d;
    logic [CNT_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    if (STAGES == 1) begin : g_one
        assign in_adv = !vld_q[0] || bus.out_ready;

        always_comb begin
            vld_d = vld_q;
            res_d = res_q;
            if (in_adv) begin
                vld_d[0] = bus.in_valid;
                if (bus.in_valid) begin
                    res_d = resolve(bus.cmpop, eq_c, lts_c, ltu_c, bus.pred_taken, bus.tag_in);
                end
            end
            if (bus.flush) vld_d = '0;
        end
    end else begin : g_two
        // Stage 0 keeps only the three compare flags; the funct3 select happens in stage 1.
        typedef struct packed {
            logic             eq;
            logic             lts;
            logic             ltu;
            logic [2:0]       cmpop;
            logic             pred;
            logic [TAG_W-1:0] tag;
        } s0_t;

        s0_t  s0_q, s0_d;
        logic last_adv;

        assign last_adv = !vld_q[STAGES-1] || bus.out_ready;
        assign in_adv   = !vld_q[0] || last_adv;

        always_comb begin
            vld_d = vld_q;
            res_d = res_q;
            s0_d  = s0_q;
            if (last_adv) begin
                vld_d[STAGES-1] = vld_q[0];
                if (vld_q[0]) begin
                    res_d = resolve(s0_q.cmpop, s0_q.eq, s0_q.lts, s0_q.ltu, s0_q.pred, s0_q.tag);
                end
            end
            if (in_adv) begin
                vld_d[0] = bus.in_valid;
                if (bus.in_valid) begin
                    s0_d.eq    = eq_c;
                    s0_d.lts   = lts_c;
                    s0_d.ltu   = ltu_c;
                    s0_d.cmpop = bus.cmpop;
                    s0_d.pred  = bus.pred_taken;
                    s0_d.tag   = bus.tag_in;
                end
            end
            if (bus.flush) vld_d = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) s0_q <= '0;
            else     s0_q <= s0_d;
        end
    end

    // Flush hides the last stage so no result is consumed or counted that cycle.
    assign out_valid = vld_q[STAGES-1] && !bus.flush;
    assign out_xfer  = out_valid && bus.out_ready;

    always_comb begin
        resolved_cnt_d   = resolved_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (out_xfer && !res_q.illegal) resolved_cnt_d   = resolved_cnt_q + 1'b1;
        if (out_xfer && res_q.mispredict) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q            <= '0;
            res_q            <= '0;
            resolved_cnt_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            vld_q            <= vld_d;
            res_q            <= res_d;
            resolved_cnt_q   <= resolved_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.in_ready       = in_adv;
    assign bus.out_valid      = out_valid;
    assign bus.br_en          = res_q.br_en;
    assign bus.mispredict     = res_q.mispredict;
    assign bus.illegal        = res_q.illegal;
    assign bus.tag_out        = res_q.tag;
    assign bus.resolved_cnt   = resolved_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: a STAGES=1/CNT_W=32 and a STAGES=2/CNT_W=4 instance,
// directed scenarios plus random traffic against a queue-based reference.
module tb_cmp_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        d_in_valid, d_flush, d_out_ready, d_pred;
  logic [2:0]  d_cmpop;
  logic [31:0] d_rs1, d_cmpmux;
  logic [4:0]  d_tag;

  cmp_pipe_if #(.WIDTH(32), .TAG_W(5), .CNT_W(32)) if1 ();
  cmp_pipe_if #(.WIDTH(32), .TAG_W(5), .CNT_W(4))  if2 ();

  cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if1.in_valid   = sel ? 1'b0 : d_in_valid;
  assign if1.flush      = sel ? 1'b0 : d_flush;
  assign if1.out_ready  = sel ? 1'b1 : d_out_ready;
  assign if1.cmpop      = d_cmpop;
  assign if1.rs1        = d_rs1;
  assign if1.cmpmux     = d_cmpmux;
  assign if1.pred_taken = d_pred;
  assign if1.tag_in     = d_tag;
  assign if2.in_valid   = sel ? d_in_valid : 1'b0;
  assign if2.flush      = sel ? d_flush : 1'b0;
  assign if2.out_ready  = sel ? d_out_ready : 1'b1;
  assign if2.cmpop      = d_cmpop;
  assign if2.rs1        = d_rs1;
  assign if2.cmpmux     = d_cmpmux;
  assign if2.pred_taken = d_pred;
  assign if2.tag_in     = d_tag;

  logic        o_ov, o_ir, o_br, o_mp, o_il;
  logic [4:0]  o_tag;
  logic [31:0] o_rc, o_mc;
  assign o_ov  = sel ? if2.out_valid  : if1.out_valid;
  assign o_ir  = sel ? if2.in_ready   : if1.in_ready;
  assign o_br  = sel ? if2.br_en      : if1.br_en;
  assign o_mp  = sel ? if2.mispredict : if1.mispredict;
  assign o_il  = sel ? if2.illegal    : if1.illegal;
  assign o_tag = sel ? if2.tag_out    : if1.tag_out;
  assign o_rc  = sel ? {28'd0, if2.resolved_cnt}   : if1.resolved_cnt;
  assign o_mc  = sel ? {28'd0, if2.mispredict_cnt} : if1.mispredict_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        br;
    logic        mp;
    logic        il;
    logic [4:0]  tag;
    logic [31:0] acc;
  } item_t;

  item_t       exp_q[$];
  int          head_arr = 0;
  int          edge_n = 0;
  logic [31:0] m_rc = 0, m_mc = 0;
  logic        m_acc = 1'b0;

  function automatic item_t ref_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic p, input logic [4:0] t);
    item_t r;
    int    sa, sb;
    logic  cond;
    sa = a;
    sb = b;
    r.tag = t;
    r.acc = 0;
    r.il  = 1'b0;
    case (op)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd4:    cond = (sa < sb);
      3'd5:    cond = (sa >= sb);
      3'd6:    cond = (a < b);
      3'd7:    cond = (a >= b);
      default: begin cond = 1'b0; r.il = 1'b1; end
    endcase
    r.br = cond;
    r.mp = !r.il && (cond != p);
    return r;
  endfunction

  function automatic int depth();
    return sel ? 2 : 1;
  endfunction

  function automatic logic exp_ov();
    return !d_flush && exp_q.size() > 0 && head_arr <= edge_n;
  endfunction

  function automatic logic exp_ir();
    return (exp_q.size() < depth()) || d_out_ready;
  endfunction

  // Advances the model by one clock edge using the inputs presented this cycle.
  task automatic model_edge();
    logic [31:0] mask;
    logic        ox, ix;
    item_t       it;
    mask  = sel ? 32'hF : 32'hFFFF_FFFF;
    m_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_rc = 0;
      m_mc = 0;
    end else if (d_flush) begin
      exp_q.delete();
    end else begin
      ox = exp_ov() && d_out_ready;
      ix = d_in_valid && exp_ir();
      if (ox) begin
        it = exp_q.pop_front();
        if (!it.il) m_rc = (m_rc + 1) & mask;
        if (it.mp)  m_mc = (m_mc + 1) & mask;
        if (exp_q.size() > 0) begin
          head_arr = int'(exp_q[0].acc) + depth() - 1;
          if (head_arr < edge_n + 1) head_arr = edge_n + 1;
        end
      end
      if (ix) begin
        it = ref_result(d_cmpop, d_rs1, d_cmpmux, d_pred, d_tag);
        it.acc = edge_n + 1;
        if (exp_q.size() == 0) head_arr = edge_n + depth();
        exp_q.push_back(it);
        m_acc = 1'b1;
      end
    end
    edge_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    d_in_valid = 0; d_flush = 0; d_out_ready = 1; d_pred = 0;
    d_cmpop = 0; d_rs1 = 0; d_cmpmux = 0; d_tag = 0;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic p, input logic [4:0] t);
    d_in_valid = 1; d_cmpop = op; d_rs1 = a; d_cmpmux = b; d_pred = p; d_tag = t;
  endtask

  task automatic do_reset(input logic s);
    drive_idle();
    sel = s;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset(input logic s);
    sel = s;
    rst = 1;
    drive_op(3'b001, 32'd1, 32'd2, 1'b1, 5'd9);
    d_flush = 1;
    tick();
    tick();
    rst = 0;
    drive_idle();
    @(negedge clk);
    n_total++; if (o_ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid s=%0d: got %b want 0", s, o_ov); end
    n_total++; if (o_ir !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready s=%0d: got %b want 1", s, o_ir); end
    n_total++; if ({o_br, o_mp, o_il, o_tag} !== 8'h00) begin n_bad++; $display("FAIL reset_payload s=%0d: got %h want 00", s, {o_br, o_mp, o_il, o_tag}); end
    n_total++; if (o_rc !== 0 || o_mc !== 0) begin n_bad++; $display("FAIL reset_counters s=%0d: got %0d/%0d want 0/0", s, o_rc, o_mc); end
  endtask

  task automatic test_signed_unsigned();
    logic [2:0] ops[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [3:0] br_e = 4'b1001;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_op(ops[i], 32'hFFFF_FFFF, 32'd1, 1'b0, 5'(i));
      else d_in_valid = 0;
      @(negedge clk);
      if (i == 0) begin
        n_total++; if (o_ov !== 1'b0) begin n_bad++; $display("FAIL s1_first_ov: got %b want 0", o_ov); end
      end else begin
        n_total++; if (o_ov !== 1'b1) begin n_bad++; $display("FAIL s1_ov i=%0d: got %b want 1", i, o_ov); end
        n_total++; if ({o_br, o_mp, o_tag} !== {br_e[i-1], br_e[i-1], 5'(i-1)}) begin
          n_bad++; $display("FAIL s1_result i=%0d: got br=%b mp=%b tag=%0d want br=%b mp=%b tag=%0d", i, o_br, o_mp, o_tag, br_e[i-1], br_e[i-1], i-1);
        end
        n_total++; if (o_rc !== 32'(i-1)) begin n_bad++; $display("FAIL s1_rc i=%0d: got %0d want %0d", i, o_rc, i-1); end
      end
      tick();
    end
    @(negedge clk);
    n_total++; if (o_ov !== 1'b0) begin n_bad++; $display("FAIL s1_drained_ov: got %b want 0", o_ov); end
    n_total++; if (o_rc !== 32'd4 || o_mc !== 32'd2) begin n_bad++; $display("FAIL s1_counts: got %0d/%0d want 4/2", o_rc, o_mc); end
  endtask

  task automatic test_back_to_back();
    int e_ov[5]  = '{0, 0, 1, 1, 0};
    int e_br[5]  = '{0, 0, 1, 0, 0};
    int e_tag[5] = '{0, 0, 3, 4, 0};
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive_op(3'b000, 32'h1234, 32'h1234, 1'b0, 5'd3);
      else if (c == 1) drive_op(3'b001, 32'h1234, 32'h1234, 1'b0, 5'd4);
      else d_in_valid = 0;
      @(negedge clk);
      n_total++; if (o_ov !== 1'(e_ov[c])) begin n_bad++; $display("FAIL b2b_ov c=%0d: got %b want %0d", c, o_ov, e_ov[c]); end
      if (e_ov[c] == 1) begin
        n_total++; if ({o_br, o_tag} !== {1'(e_br[c]), 5'(e_tag[c])}) begin
          n_bad++; $display("FAIL b2b_result c=%0d: got br=%b tag=%0d want br=%0d tag=%0d", c, o_br, o_tag, e_br[c], e_tag[c]);
        end
      end
      tick();
    end
    @(negedge clk);
    n_total++; if (o_rc !== 32'd2 || o_mc !== 32'd1) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want 2/1", o_rc, o_mc); end
  endtask

  task automatic test_stall();
    logic [2:0]  r_op[3]  = '{3'b000, 3'b001, 3'b110};
    logic [31:0] r_a[3]   = '{32'd5, 32'd5, 32'd1};
    logic [31:0] r_b[3]   = '{32'd5, 32'd5, 32'd2};
    logic [4:0]  r_tag[3] = '{5'd10, 5'd11, 5'd12};
    logic        r_br[3]  = '{1'b1, 1'b0, 1'b1};
    int req[9]  = '{0, 1, 2, 2, 2, 2, -1, -1, -1};
    int ordy[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    int e_ov[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    int e_ir[9] = '{1, 1, 0, 0, 0, 1, -1, -1, -1};
    int e_rs[9] = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};
    do_reset(1'b1);
    for (int c = 0; c < 9; c++) begin
      if (req[c] >= 0) drive_op(r_op[req[c]], r_a[req[c]], r_b[req[c]], 1'b1, r_tag[req[c]]);
      else d_in_valid = 0;
      d_out_ready = 1'(ordy[c]);
      @(negedge clk);
      n_total++; if (o_ov !== 1'(e_ov[c])) begin n_bad++; $display("FAIL stall_ov c=%0d: got %b want %0d", c, o_ov, e_ov[c]); end
      if (e_ir[c] >= 0) begin
        n_total++; if (o_ir !== 1'(e_ir[c])) begin n_bad++; $display("FAIL stall_in_ready c=%0d: got %b want %0d", c, o_ir, e_ir[c]); end
      end
      if (e_rs[c] >= 0) begin
        n_total++; if ({o_br, o_mp, o_tag} !== {r_br[e_rs[c]], !r_br[e_rs[c]], r_tag[e_rs[c]]}) begin
          n_bad++; $display("FAIL stall_result c=%0d: got br=%b mp=%b tag=%0d want tag=%0d", c, o_br, o_mp, o_tag, r_tag[e_rs[c]]);
        end
      end
      tick();
    end
    @(negedge clk);
    n_total++; if (o_rc !== 32'd3 || o_mc !== 32'd1) begin n_bad++; $display("FAIL stall_counts: got %0d/%0d want 3/1", o_rc, o_mc); end
  endtask

  task automatic test_illegal(input logic s);
    int n;
    do_reset(s);
    drive_op(3'b010, 32'd7, 32'd7, 1'b1, 5'd7);
    tick();
    d_in_valid = 0;
    n = 0;
    @(negedge clk);
    while (!o_ov && n < 6) begin tick(); @(negedge clk); n++; end
    n_total++; if (o_ov !== 1'b1) begin n_bad++; $display("FAIL illegal_timeout s=%0d: got ov=%b want 1", s, o_ov); end
    n_total++; if ({o_il, o_br, o_mp, o_tag} !== {3'b100, 5'd7}) begin
      n_bad++; $display("FAIL illegal_result s=%0d: got il=%b br=%b mp=%b tag=%0d want 1/0/0/7", s, o_il, o_br, o_mp, o_tag);
    end
    tick();
    @(negedge clk);
    n_total++; if (o_ov !== 1'b0 || o_rc !== 0 || o_mc !== 0) begin
      n_bad++; $display("FAIL illegal_after s=%0d: got ov=%b rc=%0d mc=%0d want 0/0/0", s, o_ov, o_rc, o_mc);
    end
  endtask

  task automatic test_flush();
    int n;
    do_reset(1'b1);
    drive_op(3'b000, 32'd5, 32'd5, 1'b1, 5'd1);
    tick();
    drive_op(3'b000, 32'd6, 32'd6, 1'b1, 5'd2);
    tick();
    drive_op(3'b000, 32'd7, 32'd7, 1'b1, 5'd3);
    d_flush = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++; if (o_ov !== 1'b0) begin n_bad++; $display("FAIL flush_ov c=%0d: got %b want 0", c, o_ov); end
      tick();
      d_flush = 0;
      d_in_valid = 0;
    end
    n_total++; if (o_rc !== 0 || o_mc !== 0) begin n_bad++; $display("FAIL flush_counts: got %0d/%0d want 0/0", o_rc, o_mc); end
    drive_op(3'b001, 32'd1, 32'd2, 1'b0, 5'd9);
    tick();
    d_in_valid = 0;
    n = 0;
    @(negedge clk);
    while (!o_ov && n < 6) begin tick(); @(negedge clk); n++; end
    n_total++; if ({o_ov, o_br, o_mp, o_tag} !== {3'b111, 5'd9}) begin
      n_bad++; $display("FAIL flush_next: got ov=%b br=%b mp=%b tag=%0d want 1/1/1/9", o_ov, o_br, o_mp, o_tag);
    end
    tick();
    @(negedge clk);
    n_total++; if (o_rc !== 32'd1 || o_mc !== 32'd1) begin n_bad++; $display("FAIL flush_next_counts: got %0d/%0d want 1/1", o_rc, o_mc); end
  endtask

  task automatic test_wrap();
    logic [2:0] legal[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    item_t      r;
    int         mis = 0;
    do_reset(1'b1);
    for (int i = 0; i < 17; i++) begin
      drive_op(legal[$urandom_range(0, 5)], pick_val(), pick_val(), 1'($urandom), 5'($urandom));
      r = ref_result(d_cmpop, d_rs1, d_cmpmux, d_pred, d_tag);
      if (r.mp) mis++;
      tick();
    end
    d_in_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (o_rc !== 32'd1) begin n_bad++; $display("FAIL wrap_resolved: got %0d want 1", o_rc); end
    n_total++; if (o_mc !== 32'(mis % 16)) begin n_bad++; $display("FAIL wrap_mispredict: got %0d want %0d", o_mc, mis % 16); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_op(3'b000, 32'd3, 32'd3, 1'b0, 5'(i + 1));
      tick();
    end
    rst = 1;
    @(negedge clk);
    n_total++; if (o_rc !== 32'd2 || o_mc !== 32'd2) begin n_bad++; $display("FAIL midrst_before: got %0d/%0d want 2/2", o_rc, o_mc); end
    tick();
    rst = 0;
    d_in_valid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++; if (o_ov !== 1'b0 || o_ir !== 1'b1) begin n_bad++; $display("FAIL midrst_flow c=%0d: got ov=%b ir=%b want 0/1", c, o_ov, o_ir); end
      n_total++; if (o_rc !== 0 || o_mc !== 0) begin n_bad++; $display("FAIL midrst_counts c=%0d: got %0d/%0d want 0/0", c, o_rc, o_mc); end
      tick();
    end
  endtask

  task automatic test_random(input logic s, input int cycles);
    item_t h;
    do_reset(s);
    for (int c = 0; c < cycles; c++) begin
      if (!d_in_valid || m_acc) begin
        d_in_valid = ($urandom_range(0, 3) != 0);
        d_cmpop    = 3'($urandom_range(0, 7));
        d_rs1      = pick_val();
        d_cmpmux   = ($urandom_range(0, 3) == 0) ? d_rs1 : pick_val();
        d_pred     = 1'($urandom);
        d_tag      = 5'($urandom);
      end
      d_out_ready = ($urandom_range(0, 3) != 0);
      d_flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      n_total++; if (o_ov !== exp_ov()) begin n_bad++; $display("FAIL rnd_ov s=%0d c=%0d: got %b want %b", s, c, o_ov, exp_ov()); end
      if (!d_flush) begin
        n_total++; if (o_ir !== exp_ir()) begin n_bad++; $display("FAIL rnd_in_ready s=%0d c=%0d: got %b want %b", s, c, o_ir, exp_ir()); end
      end
      if (exp_ov()) begin
        h = exp_q[0];
        n_total++; if ({o_br, o_mp, o_il, o_tag} !== {h.br, h.mp, h.il, h.tag}) begin
          n_bad++; $display("FAIL rnd_result s=%0d c=%0d: got %h want %h", s, c, {o_br, o_mp, o_il, o_tag}, {h.br, h.mp, h.il, h.tag});
        end
      end
      n_total++; if (o_rc !== m_rc || o_mc !== m_mc) begin
        n_bad++; $display("FAIL rnd_counts s=%0d c=%0d: got %0d/%0d want %0d/%0d", s, c, o_rc, o_mc, m_rc, m_mc);
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    test_reset(1'b0);
    test_reset(1'b1);
    test_signed_unsigned();
    test_back_to_back();
    test_stall();
    test_illegal(1'b0);
    test_illegal(1'b1);
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
